// File: rtl/dmem_dump_arbiter.sv
// rtl/dmem_dump_arbiter.sv - data RAM port arbiter between pipeline MEM stage and debug dump sequencer
module dmem_dump_arbiter #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int N_WORDS = 256
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_mem_we,
  input  logic [NB_DATA-1:0] i_mem_addr,
  input  logic [NB_DATA-1:0] i_mem_wdata,
  output logic [NB_DATA-1:0] o_mem_rdata,
  input  logic               i_halt,
  input  logic               i_dump_start,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_valid,
  input  logic               i_dump_ready,
  output logic               o_dump_busy,
  output logic               o_dump_done,
  output logic               o_pipe_stall,
  output logic               o_ram_we,
  output logic [NB_ADDR-1:0] o_ram_addr,
  output logic [NB_DATA-1:0] o_ram_wdata,
  input  logic [NB_DATA-1:0] i_ram_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HALT,
    ST_READ,
    ST_SEND,
    ST_DONE
  } state_t;

  // Last dumped word address; the sequencer stops on this compare so cnt never wraps.
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);

  state_t             state;
  logic [NB_ADDR-1:0] cnt;
  logic               debug_owns;

  // Only the low NB_ADDR address bits select a RAM word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_mem_addr[NB_DATA-1:NB_ADDR];

  // Dump sequencer: state, word counter and all handshake/status outputs registered together.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      o_dump_data  <= '0;
      o_dump_valid <= 1'b0;
      o_dump_done  <= 1'b0;
      o_dump_busy  <= 1'b0;
      o_pipe_stall <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_dump_start) begin
            state       <= ST_WAIT_HALT;
            cnt         <= '0;
            o_dump_busy <= 1'b1;
          end
        end
        ST_WAIT_HALT: begin
          if (i_halt) begin
            state        <= ST_READ;
            o_pipe_stall <= 1'b1;
          end
        end
        ST_READ: begin
          o_dump_data  <= i_ram_rdata;
          o_dump_valid <= 1'b1;
          state        <= ST_SEND;
        end
        ST_SEND: begin
          if (i_dump_ready) begin
            o_dump_valid <= 1'b0;
            if (cnt == LAST_ADDR) begin
              state       <= ST_DONE;
              o_dump_done <= 1'b1;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          o_dump_done  <= 1'b0;
          o_dump_busy  <= 1'b0;
          o_pipe_stall <= 1'b0;
          state        <= ST_IDLE;
        end
        default: begin
          state        <= ST_IDLE;
          o_dump_valid <= 1'b0;
          o_dump_done  <= 1'b0;
          o_dump_busy  <= 1'b0;
          o_pipe_stall <= 1'b0;
        end
      endcase
    end
  end

  // Debug holds the port from READ through DONE; decoded from the registered state only.
  always_comb begin
    debug_owns = (state == ST_READ) || (state == ST_SEND) || (state == ST_DONE);
  end

  // RAM port mux; pipeline stores are dropped while debug owns the port and during reset.
  always_comb begin
    o_ram_we    = 1'b0;
    o_ram_addr  = cnt;
    o_ram_wdata = '0;
    if (!debug_owns) begin
      o_ram_we    = i_mem_we & i_rst_n;
      o_ram_addr  = i_mem_addr[NB_ADDR-1:0];
      o_ram_wdata = i_mem_wdata;
    end
  end

  // Read data always passes straight through to the pipeline.
  always_comb begin
    o_mem_rdata = i_ram_rdata;
  end

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// tb/tb_dmem_dump_arbiter.sv - self-checking bench for dmem_dump_arbiter
module tb_dmem_dump_arbiter;
  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 8;
  localparam int N_WORDS = 4;

  logic               clk = 1'b0;
  logic               i_rst_n = 1'b1;
  logic               i_mem_we = 1'b0;
  logic [NB_DATA-1:0] i_mem_addr = '0;
  logic [NB_DATA-1:0] i_mem_wdata = '0;
  logic [NB_DATA-1:0] o_mem_rdata;
  logic               i_halt = 1'b0;
  logic               i_dump_start = 1'b0;
  logic [NB_DATA-1:0] o_dump_data;
  logic               o_dump_valid;
  logic               i_dump_ready = 1'b0;
  logic               o_dump_busy;
  logic               o_dump_done;
  logic               o_pipe_stall;
  logic               o_ram_we;
  logic [NB_ADDR-1:0] o_ram_addr;
  logic [NB_DATA-1:0] o_ram_wdata;
  logic [NB_DATA-1:0] i_ram_rdata;

  always #5 clk = ~clk;

  dmem_dump_arbiter #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .N_WORDS(N_WORDS)) dut (
    .clk(clk), .i_rst_n(i_rst_n),
    .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .o_mem_rdata(o_mem_rdata), .i_halt(i_halt), .i_dump_start(i_dump_start),
    .o_dump_data(o_dump_data), .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready),
    .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done), .o_pipe_stall(o_pipe_stall),
    .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
    .i_ram_rdata(i_ram_rdata)
  );

  // Environment RAM: async read, synchronous write.
  logic [NB_DATA-1:0] ram [256];
  assign i_ram_rdata = ram[o_ram_addr];
  always @(posedge clk) if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: dump progress as flags plus a word index, memory as a plain array.
  logic [NB_DATA-1:0] ref_mem [256];
  bit m_wait, m_own, m_fetch, m_offer, m_done;
  int m_idx = 0;
  logic [NB_DATA-1:0] m_data = '0;
  int cyc = 0;

  always @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_wait = 0; m_own = 0; m_fetch = 0; m_offer = 0; m_done = 0;
      m_idx = 0; m_data = '0;
    end else begin
      cyc++;
      if (!m_own && i_mem_we) ref_mem[i_mem_addr[7:0]] = i_mem_wdata;
      if (m_done) begin
        m_done = 0; m_own = 0;
      end else if (m_offer) begin
        if (i_dump_ready) begin
          m_offer = 0;
          if (m_idx == N_WORDS - 1) m_done = 1;
          else begin m_idx++; m_fetch = 1; end
        end
      end else if (m_fetch) begin
        m_data = ref_mem[m_idx]; m_offer = 1; m_fetch = 0;
      end else if (m_wait) begin
        if (i_halt) begin m_wait = 0; m_own = 1; m_fetch = 1; end
      end else if (i_dump_start) begin
        m_wait = 1; m_idx = 0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [7:0] exp_addr;
    exp_addr = m_own ? 8'(m_idx) : i_mem_addr[7:0];
    chk("busy", 32'(o_dump_busy), 32'(m_wait | m_own));
    chk("stall", 32'(o_pipe_stall), 32'(m_own));
    chk("valid", 32'(o_dump_valid), 32'(m_offer));
    chk("done", 32'(o_dump_done), 32'(m_done));
    chk("dump_data", o_dump_data, m_data);
    chk("ram_we", 32'(o_ram_we), 32'(i_rst_n && !m_own && i_mem_we));
    chk("ram_addr", 32'(o_ram_addr), 32'(exp_addr));
    chk("ram_wdata", o_ram_wdata, m_own ? 32'h0 : i_mem_wdata);
    chk("mem_rdata", o_mem_rdata, ref_mem[exp_addr]);
  end

  // Handshake / completion log used by directed checks.
  logic [NB_DATA-1:0] beat_q[$];
  int edge_q[$];
  int done_edge = -1;
  int drop_edge = -1;
  bit prev_busy = 0;

  always @(negedge clk) begin
    #2;
    if (i_rst_n && o_dump_valid && i_dump_ready) begin
      beat_q.push_back(o_dump_data);
      edge_q.push_back(cyc + 1);
    end
    if (o_dump_done) done_edge = cyc;
    if (prev_busy && !o_dump_busy) drop_edge = cyc;
    prev_busy = o_dump_busy;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    beat_q.delete(); edge_q.delete(); done_edge = -1; drop_edge = -1;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (!o_dump_done && k < lim) begin tick(); k++; end
    chk("done_seen", 32'(o_dump_done), 32'd1);
    tick(); tick();
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_beats"}, 32'(beat_q.size()), 32'd4);
    for (int i = 0; i < beat_q.size() && i < 4; i++)
      chk({tag, "_word"}, beat_q[i], 32'h11 * (i + 1));
  endtask

  task automatic start_pulse();
    i_dump_start = 1'b1; tick(); i_dump_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    #1 i_rst_n = 1'b0;
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
    // Reset state
    chk("rst_valid", 32'(o_dump_valid), 0);
    chk("rst_busy", 32'(o_dump_busy), 0);
    chk("rst_stall", 32'(o_pipe_stall), 0);
    chk("rst_done", 32'(o_dump_done), 0);
    chk("rst_data", o_dump_data, 0);

    // Passthrough store and read-back
    i_mem_we = 1; i_mem_addr = 32'h10; i_mem_wdata = 32'hDEADBEEF;
    #1;
    chk("pt_we", 32'(o_ram_we), 1);
    chk("pt_addr", 32'(o_ram_addr), 32'h10);
    tick();
    i_mem_we = 0; #1;
    chk("pt_rdata", o_mem_rdata, 32'hDEADBEEF);

    // Preload words 0..3
    for (int i = 0; i < 4; i++) begin
      i_mem_we = 1; i_mem_addr = i; i_mem_wdata = 32'h11 * (i + 1); tick();
    end
    i_mem_we = 0;

    // Full dump, no backpressure
    clear_log();
    i_halt = 1; i_dump_ready = 1;
    start_pulse();
    wait_done(60);
    check_beats("full");
    if (edge_q.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("full_spacing", 32'(edge_q[i] - edge_q[i-1]), 2);
      chk("full_done_edge", 32'(done_edge), 32'(edge_q[3]));
    end
    chk("full_busy_drop", 32'(drop_edge), 32'(done_edge + 1));

    // Backpressure on word 2
    clear_log();
    start_pulse();
    for (int k = 0; k < 40 && !(o_dump_valid && o_dump_data == 32'h33); k++) tick();
    i_dump_ready = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(o_dump_valid), 1);
      chk("bp_data", o_dump_data, 32'h33);
      chk("bp_stall", 32'(o_pipe_stall), 1);
      chk("bp_cnt", 32'(o_ram_addr), 2);
    end
    i_dump_ready = 1;
    wait_done(60);
    check_beats("bp");

    // Halt gating
    clear_log();
    i_halt = 0;
    start_pulse();
    for (int k = 0; k < 10; k++) begin
      i_mem_we = 1; i_mem_addr = 32'h20 + k; i_mem_wdata = $urandom;
      #1;
      chk("hg_busy", 32'(o_dump_busy), 1);
      chk("hg_stall", 32'(o_pipe_stall), 0);
      chk("hg_we", 32'(o_ram_we), 1);
      tick();
    end
    i_mem_we = 0; i_halt = 1;
    tick();
    chk("hg_read_stall", 32'(o_pipe_stall), 1);
    wait_done(60);
    check_beats("hg");

    // Start while busy
    clear_log();
    start_pulse();
    for (int k = 0; k < 4; k++) tick();
    start_pulse();
    wait_done(60);
    check_beats("sb");
    chk("sb_idle", 32'(o_dump_busy), 0);

    // Reset mid-dump in SEND of word 1
    clear_log();
    start_pulse();
    for (int k = 0; k < 40 && !(o_dump_valid && o_dump_data == 32'h22); k++) tick();
    i_dump_ready = 0;
    tick();
    i_mem_we = 1; i_mem_addr = 32'h3; i_mem_wdata = 32'hBAD0BAD0;
    i_rst_n = 0;
    #1;
    chk("mr_valid", 32'(o_dump_valid), 0);
    chk("mr_data", o_dump_data, 0);
    chk("mr_busy", 32'(o_dump_busy), 0);
    chk("mr_stall", 32'(o_pipe_stall), 0);
    chk("mr_ram_we", 32'(o_ram_we), 0);
    tick(); tick();
    i_mem_we = 0; i_rst_n = 1;
    tick();
    chk("mr_idle", 32'(o_dump_busy), 0);
    clear_log();
    i_dump_ready = 1;
    start_pulse();
    wait_done(60);
    check_beats("mr");

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      i_halt       = ($urandom_range(0, 9) < 7);
      i_dump_start = ($urandom_range(0, 19) == 0);
      i_dump_ready = ($urandom_range(0, 9) < 6);
      i_mem_we     = ($urandom_range(0, 9) < 4);
      i_mem_addr   = $urandom;
      i_mem_wdata  = $urandom;
      tick();
    end
    i_mem_we = 0; i_dump_start = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
